// File: rtl/github_username_top.sv
// Single-digit up/down counter with prescaler and 7-segment decode, packed onto an 8-bit tile.
// Define GHU_BCD_WRAP_EN for a decimal (0-9) counter; otherwise the counter runs 0-F.
module github_username_top #(
    parameter int unsigned PRESCALE_MAX = 0
) (
    input  logic [7:0] io_i,
    output logic [7:0] io_o
);

    localparam logic [15:0] PRE_LAST = PRESCALE_MAX[15:0];
`ifdef GHU_BCD_WRAP_EN
    localparam logic [3:0] CNT_MAX = 4'd9;
`else
    localparam logic [3:0] CNT_MAX = 4'd15;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic       dir;
    logic       load;
    logic [2:0] load_val;

    assign clk      = io_i[0];
    assign rst      = io_i[1];
    assign en       = io_i[2];
    assign dir      = io_i[3];
    assign load     = io_i[4];
    assign load_val = io_i[7:5];

    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] pre_q, pre_d;
    logic        wrap_q, wrap_d;
    logic [6:0]  seg;

    always_comb begin
        cnt_d  = cnt_q;
        pre_d  = pre_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d = {1'b0, load_val};
            pre_d = '0;
        end else if (en) begin
            if (pre_q != PRE_LAST) begin
                pre_d = pre_q + 16'd1;
            end else begin
                pre_d = '0;
                if (!dir) begin
`ifdef GHU_BCD_WRAP_EN
                    // Out-of-range codes collapse to 0 and count as a wrap
                    if (cnt_q >= CNT_MAX) begin
                        cnt_d  = 4'd0;
                        wrap_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
`else
                    wrap_d = (cnt_q == CNT_MAX);
                    cnt_d  = cnt_q + 4'd1;
`endif
                end else begin
`ifdef GHU_BCD_WRAP_EN
                    if (cnt_q > CNT_MAX) begin
                        cnt_d  = 4'd0;
                        wrap_d = 1'b1;
                    end else if (cnt_q == 4'd0) begin
                        cnt_d  = CNT_MAX;
                        wrap_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
`else
                    wrap_d = (cnt_q == 4'd0);
                    cnt_d  = cnt_q - 4'd1;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            pre_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            wrap_q <= wrap_d;
        end
    end

    always_comb begin
        seg = 7'h00;
        case (cnt_q)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

    assign io_o = {wrap_q, seg};

endmodule

// File: tb/tb_github_username_top.sv
// Self-checking bench: two counter instances (prescale 0 and 2) on shared inputs,
// compared each edge against an arithmetic reference model.
module tb_github_username_top;

`ifdef GHU_BCD_WRAP_EN
    localparam int MAXV = 9;
`else
    localparam int MAXV = 15;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [2:0] lval = 3'd0;
    logic [7:0] io_i;
    logic [7:0] io_o0;
    logic [7:0] io_o2;

    int checks = 0;
    int failures = 0;

    assign io_i = {lval, load, dir, en, rst, clk};

    always #5 clk = ~clk;

    github_username_top #(.PRESCALE_MAX(0)) dut0 (.io_i(io_i), .io_o(io_o0));
    github_username_top #(.PRESCALE_MAX(2)) dut2 (.io_i(io_i), .io_o(io_o2));

    logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int PS     [2] = '{0, 2};
    int m_cnt  [2];
    int m_pre  [2];
    bit m_wrap [2];

    function automatic void model_edge(int k);
        if (rst) begin
            m_cnt[k] = 0; m_pre[k] = 0; m_wrap[k] = 0;
        end else if (load) begin
            m_cnt[k] = int'(lval); m_pre[k] = 0; m_wrap[k] = 0;
        end else if (en) begin
            if (m_pre[k] == PS[k]) begin
                m_pre[k] = 0;
                if (!dir) begin
                    m_wrap[k] = (m_cnt[k] == MAXV);
                    m_cnt[k]  = (m_cnt[k] + 1) % (MAXV + 1);
                end else begin
                    m_wrap[k] = (m_cnt[k] == 0);
                    m_cnt[k]  = (m_cnt[k] + MAXV) % (MAXV + 1);
                end
            end else begin
                m_pre[k]  = m_pre[k] + 1;
                m_wrap[k] = 0;
            end
        end else begin
            m_wrap[k] = 0;
        end
    endfunction

    function automatic logic [7:0] exp_o(int k);
        return {m_wrap[k], SEG[m_cnt[k]]};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
    endtask

    task automatic set_in(logic r, logic e, logic d, logic l, logic [2:0] v);
        rst = r; en = e; dir = d; load = l; lval = v;
    endtask

    task automatic test_reset();
        set_in(1, 0, 0, 0, 3'd0);
        tick();
        checks++;
        if (io_o0 !== 8'h3F) begin
            failures++;
            $display("FAIL reset_p0 got=%h exp=%h", io_o0, 8'h3F);
        end
        checks++;
        if (io_o2 !== 8'h3F) begin
            failures++;
            $display("FAIL reset_p2 got=%h exp=%h", io_o2, 8'h3F);
        end
        set_in(0, 0, 0, 0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (io_o0 !== 8'h3F) begin
                failures++;
                $display("FAIL reset_hold i=%0d got=%h exp=%h", i, io_o0, 8'h3F);
            end
        end
    endtask

    task automatic test_count_up();
        set_in(1, 0, 0, 0, 3'd0);
        tick();
        set_in(0, 1, 0, 0, 3'd0);
        for (int i = 1; i <= 17; i++) begin
            tick();
            checks++;
            if (io_o0 !== exp_o(0)) begin
                failures++;
                $display("FAIL count_up edge=%0d got=%h exp=%h", i, io_o0, exp_o(0));
            end
`ifndef GHU_BCD_WRAP_EN
            if (i == 16) begin
                checks++;
                if (io_o0 !== 8'hBF) begin
                    failures++;
                    $display("FAIL count_up_wrap got=%h exp=%h", io_o0, 8'hBF);
                end
            end
`endif
        end
    endtask

    task automatic test_count_down();
        set_in(1, 0, 0, 0, 3'd0);
        tick();
        set_in(0, 1, 1, 0, 3'd0);
        tick();
        checks++;
        if (io_o0 !== {1'b1, SEG[MAXV]}) begin
            failures++;
            $display("FAIL count_down_wrap got=%h exp=%h", io_o0, {1'b1, SEG[MAXV]});
        end
        tick();
        checks++;
        if (io_o0 !== {1'b0, SEG[MAXV - 1]}) begin
            failures++;
            $display("FAIL count_down_step got=%h exp=%h", io_o0, {1'b0, SEG[MAXV - 1]});
        end
    endtask

    task automatic test_load();
        set_in(0, 1, 0, 1, 3'b101);
        tick();
        checks++;
        if (io_o0 !== 8'h6D) begin
            failures++;
            $display("FAIL load got=%h exp=%h", io_o0, 8'h6D);
        end
    endtask

    task automatic test_reset_mid();
        set_in(0, 0, 0, 1, 3'd7);
        tick();
        set_in(1, 1, 0, 1, 3'd7);
        tick();
        checks++;
        if (io_o0 !== 8'h3F) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=%h", io_o0, 8'h3F);
        end
    endtask

    task automatic test_prescale();
        set_in(1, 0, 0, 0, 3'd0);
        tick();
        set_in(0, 0, 0, 1, 3'd7);
        tick();
        set_in(0, 1, 0, 0, 3'd0);
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (io_o2 !== 8'h6F) begin
            failures++;
            $display("FAIL prescale_at9 got=%h exp=%h", io_o2, 8'h6F);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (io_o2 !== 8'h6F) begin
                failures++;
                $display("FAIL prescale_hold i=%0d got=%h exp=%h", i, io_o2, 8'h6F);
            end
        end
        tick();
        checks++;
        if (io_o2 !== exp_o(1)) begin
            failures++;
            $display("FAIL prescale_step got=%h exp=%h", io_o2, exp_o(1));
        end
`ifdef GHU_BCD_WRAP_EN
        checks++;
        if (io_o2 !== 8'hBF) begin
            failures++;
            $display("FAIL bcd_wrap got=%h exp=%h", io_o2, 8'hBF);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(31) == 0), ($urandom_range(3) != 0), 1'($urandom),
                   ($urandom_range(15) == 0), 3'($urandom));
            tick();
            checks++;
            if (io_o0 !== exp_o(0)) begin
                failures++;
                $display("FAIL random_p0 i=%0d got=%h exp=%h", i, io_o0, exp_o(0));
            end
            checks++;
            if (io_o2 !== exp_o(1)) begin
                failures++;
                $display("FAIL random_p2 i=%0d got=%h exp=%h", i, io_o2, exp_o(1));
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_reset_mid();
        test_prescale();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
